// File: rtl/line_follower_pkg.sv
// Shared types and constants for the IR line-sensor sweep and the line-position error.
package line_follower_pkg;

    localparam int NUM_SENS  = 6;
    localparam int A2D_RES_W = 12;
    localparam int ERR_W     = 17;

    // Shift amounts applying the outer/middle/inner pair weights 8/4/1
    localparam int W_OUT = 3;
    localparam int W_MID = 2;
    localparam int W_IN  = 0;

    typedef logic [A2D_RES_W-1:0] sens_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        START  = 3'd2,
        WAIT   = 3'd3,
        CALC   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/line_err_calc.sv
// Combinational weighted line-position error from the six stored sensor readings.
module line_err_calc
    import line_follower_pkg::*;
(
    input  logic [NUM_SENS-1:0][A2D_RES_W-1:0] s,
    output logic signed [ERR_W-1:0]            err_nxt
);

    // Unsigned readings are zero-extended before subtracting so a difference spans +/-4095
    function automatic logic signed [ERR_W-1:0] weighted_diff(
        input sens_t a,
        input sens_t b,
        input int    sh
    );
        logic signed [A2D_RES_W:0] d;
        logic signed [ERR_W-1:0]   dx;
        d  = $signed({1'b0, a}) - $signed({1'b0, b});
        dx = ERR_W'(d);
        return dx <<< sh;
    endfunction

    logic signed [ERR_W-1:0] term_out;
    logic signed [ERR_W-1:0] term_mid;
    logic signed [ERR_W-1:0] term_in;

    always_comb begin
        term_out = weighted_diff(s[5], s[0], W_OUT);
        term_mid = weighted_diff(s[4], s[1], W_MID);
        term_in  = weighted_diff(s[3], s[2], W_IN);
        err_nxt  = term_out + term_mid + term_in;
    end

endmodule

// File: rtl/ir_sensor_sequencer.sv
// Periodic IR sensor sweep: settle emitters, convert channels 0..5 via the A2D, publish a signed line error.
module ir_sensor_sequencer
    import line_follower_pkg::*;
#(
    parameter int SETTLE_CYC = 4096,
    parameter int PERIOD_CYC = 1 << 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    cnv_cmplt,
    input  logic [A2D_RES_W-1:0]    res,
    output logic                    strt_cnv,
    output logic [2:0]              chnnl,
    output logic                    IR_en,
    output logic signed [ERR_W-1:0] err,
    output logic                    err_vld
);

    localparam int PER_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    seq_state_t                        state_q,   state_d;
    logic [PER_W-1:0]                  per_cnt_q, per_cnt_d;
    logic [SET_W-1:0]                  set_cnt_q, set_cnt_d;
    logic [2:0]                        idx_q,     idx_d;
    logic [NUM_SENS-1:0][A2D_RES_W-1:0] sens_q,   sens_d;
    logic signed [ERR_W-1:0]           err_q,     err_d;
    logic signed [ERR_W-1:0]           err_nxt;
    logic                              per_wrap;

    line_err_calc u_err_calc (
        .s       (sens_q),
        .err_nxt (err_nxt)
    );

    // Free-running period timer; its wrap is the only thing that can start a sweep
    always_comb begin
        per_wrap  = (per_cnt_q == PER_W'(PERIOD_CYC - 1));
        per_cnt_d = per_wrap ? '0 : per_cnt_q + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        set_cnt_d = set_cnt_q;
        idx_d     = idx_q;
        sens_d    = sens_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (per_wrap && en) begin
                    state_d   = SETTLE;
                    set_cnt_d = '0;
                    idx_d     = '0;
                end
            end
            SETTLE: begin
                if (set_cnt_q == SET_W'(SETTLE_CYC - 1)) begin
                    state_d = START;
                end else begin
                    set_cnt_d = set_cnt_q + 1'b1;
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                // The A2D clears cnv_cmplt on our strt_cnv, so a high level here is always fresh
                if (cnv_cmplt) begin
                    for (int i = 0; i < NUM_SENS; i++) begin
                        if (idx_q == 3'(i)) begin
                            sens_d[i] = res;
                        end
                    end
                    if (idx_q == 3'(NUM_SENS - 1)) begin
                        state_d = CALC;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = START;
                    end
                end
            end
            CALC: begin
                err_d   = err_nxt;
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            per_cnt_q <= '0;
            set_cnt_q <= '0;
            idx_q     <= '0;
            sens_q    <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            set_cnt_q <= set_cnt_d;
            idx_q     <= idx_d;
            sens_q    <= sens_d;
            err_q     <= err_d;
        end
    end

    // err is bypassed during CALC so the new value is visible in the same cycle as err_vld
    always_comb begin
        strt_cnv = (state_q == START);
        chnnl    = idx_q;
        IR_en    = (state_q == SETTLE) || (state_q == START) || (state_q == WAIT);
        err_vld  = (state_q == CALC);
        err      = err_vld ? err_nxt : err_q;
    end

endmodule
